// File: rtl/adjacency_map.sv
// adjacency_map: directed edge store with per-node successor queries.
// Each source node owns a linked list threaded through the edge memory;
// the head table holds {valid, index} of the newest edge of each source,
// so a reply streams successors newest-first.
// Optional feature: define ADJ_MAP_STATS_EN to add stat_edge_count and
// stat_query_count outputs.
module adjacency_map #(
  parameter int MAX_NODES  = 1024,
  parameter int MAX_EDGES  = 2048,
  parameter int NODE_WIDTH = $clog2(MAX_NODES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  edge_valid,
  output logic                  edge_ready,
  input  logic [NODE_WIDTH-1:0] edge_src,
  input  logic [NODE_WIDTH-1:0] edge_dst,
  input  logic                  decoding_done,
  output logic                  query_ready,
  input  logic                  query_valid,
  input  logic [NODE_WIDTH-1:0] query_data,
  input  logic                  reply_ready,
  output logic                  reply_valid,
  output logic [NODE_WIDTH-1:0] reply_data,
  output logic                  reply_last,
  output logic                  reply_no_edges_found,
  output logic                  edge_overflow
`ifdef ADJ_MAP_STATS_EN
  ,
  output logic [$clog2(MAX_EDGES+1)-1:0] stat_edge_count,
  output logic [31:0]                    stat_query_count
`endif
);

  // EW: edge index width; PW: write pointer width (must reach MAX_EDGES)
  localparam int EW = $clog2(MAX_EDGES);
  localparam int PW = $clog2(MAX_EDGES + 1);

  localparam logic [2:0] CLEAR   = 3'd0;
  localparam logic [2:0] BUILD   = 3'd1;
  localparam logic [2:0] READY   = 3'd2;
  localparam logic [2:0] FETCH   = 3'd3;
  localparam logic [2:0] PRESENT = 3'd4;
  localparam logic [2:0] EMPTY   = 3'd5;

  // Storage: head table entry and link entry are {valid, edge index}
  logic [EW:0]           head_mem [MAX_NODES];
  logic [NODE_WIDTH-1:0] dst_mem  [MAX_EDGES];
  logic [EW:0]           nxt_mem  [MAX_EDGES];

  logic [2:0]            state_reg, state_next;
  logic [NODE_WIDTH-1:0] clear_idx_reg;
  logic [PW-1:0]         wr_ptr_reg;
  logic [EW-1:0]         ptr_reg;
  logic                  edge_overflow_reg;
  logic                  no_edges_reg;
  logic                  last_hold_reg;
  logic [NODE_WIDTH-1:0] dst_rd_reg;
  logic [EW:0]           nxt_rd_reg;

  logic                  edge_full;
  logic                  edge_accept;
  logic                  query_accept;
  logic                  reply_accept;
  logic [NODE_WIDTH-1:0] head_raddr;
  logic [EW:0]           head_rdata;

  // Handshake decode and the single shared head-table read port
  always_comb begin
    edge_full    = (wr_ptr_reg == PW'(MAX_EDGES));
    edge_ready   = (state_reg == BUILD) && !edge_full;
    edge_accept  = edge_valid && edge_ready;
    query_ready  = (state_reg == READY);
    query_accept = query_valid && query_ready;
    reply_valid  = (state_reg == PRESENT) || (state_reg == EMPTY);
    reply_accept = reply_valid && reply_ready;
    head_raddr   = (state_reg == BUILD) ? edge_src : query_data;
    head_rdata   = head_mem[head_raddr];
  end

  // Reply outputs: data comes straight from the edge-memory read register;
  // last follows the fetched link while presenting, else holds its last beat
  always_comb begin
    reply_data           = dst_rd_reg;
    reply_last           = (state_reg == PRESENT) ? !nxt_rd_reg[EW] : last_hold_reg;
    reply_no_edges_found = no_edges_reg;
    edge_overflow        = edge_overflow_reg;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CLEAR:   if (clear_idx_reg == NODE_WIDTH'(MAX_NODES - 1)) state_next = BUILD;
      BUILD:   if (decoding_done) state_next = READY;
      READY:   if (query_accept) state_next = head_rdata[EW] ? FETCH : EMPTY;
      FETCH:   state_next = PRESENT;
      PRESENT: if (reply_ready) state_next = nxt_rd_reg[EW] ? FETCH : READY;
      EMPTY:   if (reply_ready) state_next = READY;
      default: state_next = CLEAR;
    endcase
  end

  // Head table: swept invalid in CLEAR, updated to the newest edge in BUILD
  always_ff @(posedge clk) begin
    if (state_reg == CLEAR) begin
      head_mem[clear_idx_reg] <= '0;
    end else if (edge_accept) begin
      head_mem[edge_src] <= {1'b1, wr_ptr_reg[EW-1:0]};
    end
  end

  // Edge memory: new edge links to the previous head; registered read in FETCH
  always_ff @(posedge clk) begin
    if (edge_accept) begin
      dst_mem[wr_ptr_reg[EW-1:0]] <= edge_dst;
      nxt_mem[wr_ptr_reg[EW-1:0]] <= head_rdata;
    end
    if (rst) begin
      dst_rd_reg <= '0;
      nxt_rd_reg <= '0;
    end else if (state_reg == FETCH) begin
      dst_rd_reg <= dst_mem[ptr_reg];
      nxt_rd_reg <= nxt_mem[ptr_reg];
    end
  end

  // Control state, pointers and sticky/holding flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= CLEAR;
      clear_idx_reg     <= '0;
      wr_ptr_reg        <= '0;
      ptr_reg           <= '0;
      edge_overflow_reg <= 1'b0;
      no_edges_reg      <= 1'b0;
      last_hold_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == CLEAR) clear_idx_reg <= clear_idx_reg + NODE_WIDTH'(1);
      if (edge_accept) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if ((state_reg == BUILD) && edge_valid && edge_full) edge_overflow_reg <= 1'b1;
      if (query_accept) begin
        ptr_reg      <= head_rdata[EW-1:0];
        no_edges_reg <= !head_rdata[EW];
        if (!head_rdata[EW]) last_hold_reg <= 1'b1;
      end
      if ((state_reg == PRESENT) && reply_accept) begin
        last_hold_reg <= !nxt_rd_reg[EW];
        if (nxt_rd_reg[EW]) ptr_reg <= nxt_rd_reg[EW-1:0];
      end
    end
  end

`ifdef ADJ_MAP_STATS_EN
  logic [31:0] query_count_reg;

  // Accepted-query counter, wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      query_count_reg <= '0;
    end else if (query_accept) begin
      query_count_reg <= query_count_reg + 32'd1;
    end
  end

  always_comb begin
    stat_edge_count  = wr_ptr_reg;
    stat_query_count = query_count_reg;
  end
`endif

endmodule

// File: tb/tb_adjacency_map.sv
// tb_adjacency_map: randomized scoreboard bench for adjacency_map.
// The reference keeps one queue of successors per node (newest first);
// queries push expected beats, a monitor pops them on each reply handshake.
module tb_adjacency_map;
  localparam int NW   = 10;
  localparam int MAXN = 1024;
  localparam int MAXE = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          edge_valid, edge_ready;
  logic [NW-1:0] edge_src, edge_dst;
  logic          decoding_done;
  logic          query_ready, query_valid;
  logic [NW-1:0] query_data;
  logic          reply_ready, reply_valid;
  logic [NW-1:0] reply_data;
  logic          reply_last, reply_no_edges_found, edge_overflow;
`ifdef ADJ_MAP_STATS_EN
  logic [11:0]   stat_edge_count;
  logic [31:0]   stat_query_count;
`endif

  always #5 clk = ~clk;

  adjacency_map dut (
    .clk(clk), .rst(rst),
    .edge_valid(edge_valid), .edge_ready(edge_ready),
    .edge_src(edge_src), .edge_dst(edge_dst),
    .decoding_done(decoding_done),
    .query_ready(query_ready), .query_valid(query_valid), .query_data(query_data),
    .reply_ready(reply_ready), .reply_valid(reply_valid), .reply_data(reply_data),
    .reply_last(reply_last), .reply_no_edges_found(reply_no_edges_found),
    .edge_overflow(edge_overflow)
`ifdef ADJ_MAP_STATS_EN
    , .stat_edge_count(stat_edge_count), .stat_query_count(stat_query_count)
`endif
  );

  typedef struct {
    logic [NW-1:0] data;
    logic          last;
    logic          noedge;
  } beat_t;

  beat_t         exp_q[$];
  logic [NW-1:0] adj[MAXN][$];
  int            edge_cnt;
  int            query_cnt;
  logic          ovf_exp;
  logic [NW-1:0] last_data;
  int            rr_mode;
  int            checks   = 0;
  int            failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // reply_ready pattern generator, changes only just after a rising edge
  initial begin
    reply_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0: reply_ready = 1'b1;
        1: reply_ready = ~reply_ready;
        2: reply_ready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  // Monitor: stall stability and scoreboard comparison on every accepted beat
  initial begin
    logic          held_v;
    logic [NW-1:0] held_data;
    logic          held_last;
    beat_t         b;
    held_v = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          check("stall_valid", 32'(reply_valid), 32'd1);
          check("stall_data", 32'(reply_data), 32'(held_data));
          check("stall_last", 32'(reply_last), 32'(held_last));
        end
        if (reply_valid && reply_ready) begin
          $display("beat data=%0d last=%0d no_edges=%0d", reply_data, reply_last, reply_no_edges_found);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%0d required=none", reply_data);
          end else begin
            b = exp_q.pop_front();
            check("beat_data", 32'(reply_data), 32'(b.data));
            check("beat_last", 32'(reply_last), 32'(b.last));
            check("beat_no_edges", 32'(reply_no_edges_found), 32'(b.noedge));
          end
        end
        held_v    = reply_valid && !reply_ready;
        held_data = reply_data;
        held_last = reply_last;
      end
    end
  end

  // Reset the DUT and the reference; optionally check the reset-state outputs
  task automatic do_reset(input bit chk);
    rst = 1'b1;
    edge_valid = 1'b0;
    query_valid = 1'b0;
    decoding_done = 1'b0;
    exp_q.delete();
    for (int i = 0; i < MAXN; i++) adj[i].delete();
    edge_cnt = 0;
    query_cnt = 0;
    ovf_exp = 1'b0;
    last_data = '0;
    @(posedge clk);
    @(negedge clk);
    if (chk) begin
      check("rst_reply_valid", 32'(reply_valid), 32'd0);
      check("rst_reply_data", 32'(reply_data), 32'd0);
      check("rst_reply_last", 32'(reply_last), 32'd0);
      check("rst_no_edges", 32'(reply_no_edges_found), 32'd0);
      check("rst_overflow", 32'(edge_overflow), 32'd0);
      check("rst_edge_ready", 32'(edge_ready), 32'd0);
      check("rst_query_ready", 32'(query_ready), 32'd0);
    end
    rst = 1'b0;
  endtask

  // Wait for the head-table sweep to finish; returns cycles spent
  task automatic wait_build(output int n, output bit saw_qr);
    bit ok;
    ok = 1'b0;
    saw_qr = 1'b0;
    n = 0;
    for (int i = 1; i <= 3000; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (query_ready) saw_qr = 1'b1;
      if (edge_ready) begin
        n = i;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL build_timeout actual=no_edge_ready required=edge_ready");
    end
  endtask

  // Offer one edge for one cycle; reference accepts it if not full
  task automatic send_edge(input int s, input int d, input bit with_done);
    bit exp_rdy;
    edge_src = NW'(s);
    edge_dst = NW'(d);
    edge_valid = 1'b1;
    if (with_done) decoding_done = 1'b1;
    exp_rdy = (edge_cnt < MAXE);
    check("edge_ready", 32'(edge_ready), 32'(exp_rdy));
    @(posedge clk);
    if (exp_rdy) begin
      adj[s].push_front(NW'(d));
      edge_cnt++;
    end else begin
      ovf_exp = 1'b1;
    end
    #1;
    edge_valid = 1'b0;
  endtask

  task automatic finish_build();
    decoding_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("query_ready_after_done", 32'(query_ready), 32'd1);
  endtask

  // Wait until the scoreboard drains, then query_ready must be back
  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL reply_timeout actual=%0d_pending required=0", exp_q.size());
    end
    @(negedge clk);
    check("query_ready_after_last", 32'(query_ready), 32'd1);
  endtask

  // Issue a query, push its expected beats, check first-beat latency
  task automatic do_query(input int n, input bit wait_end);
    bit ok;
    bit empty_exp;
    int sz;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (query_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL query_ready_timeout actual=0 required=1");
      return;
    end
    $display("query node=%0d expected_beats=%0d", n, adj[n].size());
    query_data = NW'(n);
    query_valid = 1'b1;
    @(posedge clk);
    sz = adj[n].size();
    empty_exp = (sz == 0);
    if (empty_exp) begin
      exp_q.push_back('{last_data, 1'b1, 1'b1});
    end else begin
      for (int i = 0; i < sz; i++) exp_q.push_back('{adj[n][i], (i == sz - 1), 1'b0});
      last_data = adj[n][sz-1];
    end
    query_cnt++;
    #1;
    query_valid = 1'b0;
    @(negedge clk);
    check("latency_t1_valid", 32'(reply_valid), 32'(empty_exp));
    if (!empty_exp) begin
      @(negedge clk);
      check("latency_t2_valid", 32'(reply_valid), 32'd1);
    end
    if (wait_end) wait_done();
  endtask

  initial begin
    int  n;
    bit  saw_qr;
    rr_mode = 3;
    rst = 1'b1;
    edge_valid = 1'b0;
    edge_src = '0;
    edge_dst = '0;
    decoding_done = 1'b0;
    query_valid = 1'b0;
    query_data = '0;

    // Reset and the head-table sweep: 1024 cycles with no handshakes
    do_reset(1'b1);
    wait_build(n, saw_qr);
    check("clear_cycles", 32'(n), 32'd1024);
    check("query_ready_during_clear", 32'(saw_qr), 32'd0);

    // Three successors of node 3, last edge in the same cycle as done
    send_edge(3, 5, 1'b0);
    send_edge(3, 7, 1'b0);
    send_edge(3, 9, 1'b1);
    @(negedge clk);
    check("query_ready_ready_state", 32'(query_ready), 32'd1);
    check("edge_ready_ready_state", 32'(edge_ready), 32'd0);
    check("no_overflow", 32'(edge_overflow), 32'd0);
`ifdef ADJ_MAP_STATS_EN
    check("stat_edges", 32'(stat_edge_count), 32'(edge_cnt));
`endif
    rr_mode = 0;
    do_query(3, 1'b1);

    // Empty node held for 10 stalled cycles
    rr_mode = 3;
    reply_ready = 1'b0;
    do_query(4, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("empty_hold_valid", 32'(reply_valid), 32'd1);
      check("empty_hold_last", 32'(reply_last), 32'd1);
      check("empty_hold_no_edges", 32'(reply_no_edges_found), 32'd1);
    end
    @(posedge clk);
    #1;
    reply_ready = 1'b1;
    wait_done();

    // Backpressure: toggling and random reply_ready
    rr_mode = 1;
    do_query(3, 1'b1);
    rr_mode = 2;
    do_query(3, 1'b1);
    do_query(4, 1'b1);
`ifdef ADJ_MAP_STATS_EN
    check("stat_queries", stat_query_count, 32'(query_cnt));
`endif

    // Reset after the first beat of a reply aborts it and forgets all edges
    rr_mode = 3;
    @(posedge clk);
    #1;
    reply_ready = 1'b0;
    do_query(3, 1'b0);
    check("abort_first_data", 32'(reply_data), 32'd9);
    @(posedge clk);
    #1;
    reply_ready = 1'b1;
    @(posedge clk);
    #1;
    reply_ready = 1'b0;
    do_reset(1'b1);
    wait_build(n, saw_qr);
    check("clear_cycles_again", 32'(n), 32'd1024);
    finish_build();
    rr_mode = 0;
    do_query(3, 1'b1);

    // Random graph over a small node range: self-loops and multi-edges likely
    do_reset(1'b0);
    wait_build(n, saw_qr);
    for (int i = 0; i < 80; i++) send_edge($urandom_range(0, 15), $urandom_range(0, 15), 1'b0);
    send_edge(2, 2, 1'b0);
    send_edge(2, 2, 1'b0);
    finish_build();
    check("random_no_overflow", 32'(edge_overflow), 32'd0);
    for (int i = 0; i < 24; i++) begin
      rr_mode = $urandom_range(0, 2);
      do_query((i == 0) ? 2 : $urandom_range(0, 17), 1'b1);
    end

    // Fill the edge memory, then offer one more
    do_reset(1'b0);
    wait_build(n, saw_qr);
    for (int i = 0; i < MAXE + 1; i++) send_edge($urandom_range(0, 7), $urandom_range(0, MAXN - 1), 1'b0);
    @(negedge clk);
    check("full_edge_ready", 32'(edge_ready), 32'd0);
    check("overflow_sticky", 32'(edge_overflow), 32'(ovf_exp));
`ifdef ADJ_MAP_STATS_EN
    check("stat_edges_full", 32'(stat_edge_count), 32'(edge_cnt));
`endif
    finish_build();
    rr_mode = 0;
    for (int i = 0; i < 8; i++) do_query(i, 1'b1);
    check("overflow_after_queries", 32'(edge_overflow), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
